// File: rtl/sub_bytes_hamming_decoder.sv
// sub_bytes_hamming_decoder
// Two-stage streaming single-error-correcting decoder for Hamming(12,8)
// SubBytes codewords {data[7:0], check[3:0]}. S1 holds the codeword and its
// syndrome, S2 holds the corrected byte and flags. Saturating counters and a
// sticky flag summarise error activity for the fault monitor.
module sub_bytes_hamming_decoder #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [11:0]      in_cw,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_data,
   output logic             out_corrected,
   output logic             out_uncorrectable,
   input  logic             clr_counts,
   output logic [CNT_W-1:0] corr_count,
   output logic [CNT_W-1:0] uncorr_count,
   output logic             uncorr_sticky
);

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   // Check bits as produced by the upstream predictor.
   function automatic logic [3:0] calc_check(input logic [7:0] d);
      logic [3:0] w;
      w[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
      w[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
      w[2] = d[1] ^ d[2] ^ d[3] ^ d[7];
      w[3] = d[4] ^ d[5] ^ d[6] ^ d[7];
      return w;
   endfunction

   // Syndrome read as a Hamming position; only data positions produce a flip.
   function automatic logic [7:0] syn_to_mask(input logic [3:0] syn);
      logic [7:0] m;
      case (syn)
         4'd3:    m = 8'h01;
         4'd5:    m = 8'h02;
         4'd6:    m = 8'h04;
         4'd7:    m = 8'h08;
         4'd9:    m = 8'h10;
         4'd10:   m = 8'h20;
         4'd11:   m = 8'h40;
         4'd12:   m = 8'h80;
         default: m = 8'h00;
      endcase
      return m;
   endfunction

   // Increment that sticks at the all-ones value instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] r;
      if (v == CNT_MAX) begin
         r = v;
      end else begin
         r = v + CNT_ONE;
      end
      return r;
   endfunction

   logic             s1_valid_r;
   logic [11:0]      s1_cw_r;
   logic [3:0]       s1_syn_r;
   logic             s2_valid_r;
   logic [7:0]       s2_data_r;
   logic             s2_corr_r;
   logic             s2_uncorr_r;
   logic [CNT_W-1:0] corr_cnt_r;
   logic [CNT_W-1:0] uncorr_cnt_r;
   logic             sticky_r;

   logic             s2_adv_s;
   logic             s1_adv_s;
   logic             s2_load_s;
   logic [3:0]       in_syn_s;
   logic [7:0]       dec_data_s;
   logic             dec_corr_s;
   logic             dec_uncorr_s;

   assign s2_adv_s  = !s2_valid_r || out_ready;
   assign s1_adv_s  = !s1_valid_r || s2_adv_s;
   assign s2_load_s = s2_adv_s && s1_valid_r;
   assign in_syn_s  = in_cw[3:0] ^ calc_check(in_cw[11:4]);

   // Correct the S1 word from its registered syndrome.
   always_comb begin
      dec_data_s   = s1_cw_r[11:4];
      dec_corr_s   = 1'b0;
      dec_uncorr_s = 1'b0;
      case (s1_syn_r)
         4'd0: begin
            dec_data_s = s1_cw_r[11:4];
         end
         4'd13, 4'd14, 4'd15: begin
            dec_uncorr_s = 1'b1;
         end
         default: begin
            dec_data_s = s1_cw_r[11:4] ^ syn_to_mask(s1_syn_r);
            dec_corr_s = 1'b1;
         end
      endcase
   end

   // Stage 1: capture the accepted codeword together with its syndrome.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r <= 1'b0;
         s1_cw_r    <= 12'h000;
         s1_syn_r   <= 4'h0;
      end else if (s1_adv_s) begin
         s1_valid_r <= in_valid;
         if (in_valid) begin
            s1_cw_r  <= in_cw;
            s1_syn_r <= in_syn_s;
         end
      end
   end

   // Stage 2: capture corrected data and flags; holds while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_r  <= 1'b0;
         s2_data_r   <= 8'h00;
         s2_corr_r   <= 1'b0;
         s2_uncorr_r <= 1'b0;
      end else if (s2_adv_s) begin
         s2_valid_r <= s1_valid_r;
         if (s1_valid_r) begin
            s2_data_r   <= dec_data_s;
            s2_corr_r   <= dec_corr_s;
            s2_uncorr_r <= dec_uncorr_s;
         end
      end
   end

   // Error statistics, counted as each word enters S2; clear wins over count.
   always_ff @(posedge clk) begin
      if (rst || clr_counts) begin
         corr_cnt_r   <= CNT_ZERO;
         uncorr_cnt_r <= CNT_ZERO;
         sticky_r     <= 1'b0;
      end else if (s2_load_s) begin
         if (dec_corr_s) begin
            corr_cnt_r <= sat_inc(corr_cnt_r);
         end
         if (dec_uncorr_s) begin
            uncorr_cnt_r <= sat_inc(uncorr_cnt_r);
            sticky_r     <= 1'b1;
         end
      end
   end

   assign in_ready          = s1_adv_s;
   assign out_valid         = s2_valid_r;
   assign out_data          = s2_data_r;
   assign out_corrected     = s2_corr_r;
   assign out_uncorrectable = s2_uncorr_r;
   assign corr_count        = corr_cnt_r;
   assign uncorr_count      = uncorr_cnt_r;
   assign uncorr_sticky     = sticky_r;

endmodule

// File: tb/tb_sub_bytes_hamming_decoder.sv
// Directed self-checking bench for sub_bytes_hamming_decoder (CNT_W = 2).
module tb_sub_bytes_hamming_decoder;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] in_cw;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic        out_corrected;
   logic        out_uncorrectable;
   logic        clr_counts;
   logic [1:0]  corr_count;
   logic [1:0]  uncorr_count;
   logic        uncorr_sticky;

   int errors = 0;
   int checks = 0;

   logic [11:0] bp_cw   [0:7];
   logic [7:0]  bp_data [0:7];
   logic [1:0]  bp_flag [0:7];   // {corrected, uncorrectable}

   sub_bytes_hamming_decoder #(.CNT_W(2)) dut (
      .clk               (clk),
      .rst               (rst),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_cw             (in_cw),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .out_data          (out_data),
      .out_corrected     (out_corrected),
      .out_uncorrectable (out_uncorrectable),
      .clr_counts        (clr_counts),
      .corr_count        (corr_count),
      .uncorr_count      (uncorr_count),
      .uncorr_sticky     (uncorr_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one word into an empty pipeline and stop on the cycle it is on out_*.
   task automatic drive_word(input logic [11:0] cw);
      in_cw     = cw;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_cw = 12'h000; out_ready = 1'b1; clr_counts = 1'b0;
      repeat (2) @(posedge clk);
      #1; rst = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
      checks++; if (out_corrected !== 1'b0 || out_uncorrectable !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b%b expected 00", out_corrected, out_uncorrectable); end
      checks++; if (corr_count !== 2'd0 || uncorr_count !== 2'd0) begin errors++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", corr_count, uncorr_count); end
      checks++; if (uncorr_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky: got %b expected 0", uncorr_sticky); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_clean();
      drive_word(12'h637);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clean_valid: got %b expected 1", out_valid); end
      checks++; if (out_data !== 8'h63) begin errors++; $display("FAIL clean_data: got %h expected 63", out_data); end
      checks++; if (out_corrected !== 1'b0 || out_uncorrectable !== 1'b0) begin errors++; $display("FAIL clean_flags: got %b%b expected 00", out_corrected, out_uncorrectable); end
      checks++; if (corr_count !== 2'd0 || uncorr_count !== 2'd0) begin errors++; $display("FAIL clean_counts: got %0d/%0d expected 0/0", corr_count, uncorr_count); end
   endtask

   task automatic test_data_error();
      drive_word(12'h677);
      checks++; if (out_data !== 8'h63) begin errors++; $display("FAIL data_err_data: got %h expected 63", out_data); end
      checks++; if (out_corrected !== 1'b1 || out_uncorrectable !== 1'b0) begin errors++; $display("FAIL data_err_flags: got %b%b expected 10", out_corrected, out_uncorrectable); end
      checks++; if (corr_count !== 2'd1) begin errors++; $display("FAIL data_err_count: got %0d expected 1", corr_count); end
   endtask

   task automatic test_check_error();
      drive_word(12'h63F);
      checks++; if (out_data !== 8'h63) begin errors++; $display("FAIL chk_err_data: got %h expected 63", out_data); end
      checks++; if (out_corrected !== 1'b1 || out_uncorrectable !== 1'b0) begin errors++; $display("FAIL chk_err_flags: got %b%b expected 10", out_corrected, out_uncorrectable); end
      checks++; if (corr_count !== 2'd2) begin errors++; $display("FAIL chk_err_count: got %0d expected 2", corr_count); end
   endtask

   task automatic test_uncorrectable();
      drive_word(12'hE36);
      checks++; if (out_data !== 8'hE3) begin errors++; $display("FAIL uncorr_data: got %h expected e3", out_data); end
      checks++; if (out_corrected !== 1'b0 || out_uncorrectable !== 1'b1) begin errors++; $display("FAIL uncorr_flags: got %b%b expected 01", out_corrected, out_uncorrectable); end
      checks++; if (uncorr_sticky !== 1'b1) begin errors++; $display("FAIL uncorr_sticky: got %b expected 1", uncorr_sticky); end
      checks++; if (uncorr_count !== 2'd1 || corr_count !== 2'd2) begin errors++; $display("FAIL uncorr_counts: got %0d/%0d expected 2/1", corr_count, uncorr_count); end
      drive_word(12'h637);
      checks++; if (uncorr_sticky !== 1'b1 || out_uncorrectable !== 1'b0) begin errors++; $display("FAIL sticky_hold: got sticky=%b flag=%b expected 1/0", uncorr_sticky, out_uncorrectable); end
   endtask

   task automatic test_saturation();
      logic [11:0] cw;
      logic [1:0]  exp_cnt;
      clr_counts = 1'b1;
      @(posedge clk); #1;
      clr_counts = 1'b0;
      checks++; if (corr_count !== 2'd0 || uncorr_count !== 2'd0 || uncorr_sticky !== 1'b0) begin errors++; $display("FAIL clear_idle: got %0d/%0d/%b expected 0/0/0", corr_count, uncorr_count, uncorr_sticky); end
      for (int i = 0; i < 5; i++) begin
         cw = 12'h637 ^ (12'h010 << i);
         exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
         drive_word(cw);
         checks++; if (out_data !== 8'h63 || out_corrected !== 1'b1) begin errors++; $display("FAIL sat_word%0d: got %h/%b expected 63/1", i, out_data, out_corrected); end
         checks++; if (corr_count !== exp_cnt) begin errors++; $display("FAIL sat_count%0d: got %0d expected %0d", i, corr_count, exp_cnt); end
      end
   endtask

   task automatic test_clear_priority();
      in_cw = 12'h677; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; clr_counts = 1'b1;
      @(posedge clk); #1;
      clr_counts = 1'b0;
      checks++; if (corr_count !== 2'd0) begin errors++; $display("FAIL clr_priority_count: got %0d expected 0", corr_count); end
      checks++; if (out_valid !== 1'b1 || out_data !== 8'h63 || out_corrected !== 1'b1) begin errors++; $display("FAIL clr_priority_data: got %b/%h/%b expected 1/63/1", out_valid, out_data, out_corrected); end
   endtask

   task automatic test_backpressure();
      int sent, recv, inflight;
      bit held, exp_ready;
      logic [7:0] hd;
      logic hc, hu;
      bp_cw   = '{12'h637, 12'h7C9, 12'h677, 12'h5C9, 12'h63F, 12'h7CB, 12'hE36, 12'hFC8};
      bp_data = '{8'h63, 8'h7C, 8'h63, 8'h7C, 8'h63, 8'h7C, 8'hE3, 8'hFC};
      bp_flag = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
      @(posedge clk); #1;
      sent = 0; recv = 0; held = 1'b0; hd = 8'h00; hc = 1'b0; hu = 1'b0;
      for (int cyc = 0; cyc < 80 && recv < 8; cyc++) begin
         out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
         in_valid  = (sent < 8);
         if (sent < 8) in_cw = bp_cw[sent];
         else          in_cw = 12'h000;
         #1;
         if (held) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== hd || out_corrected !== hc || out_uncorrectable !== hu) begin
               errors++; $display("FAIL bp_hold cyc%0d: got %b/%h/%b%b expected 1/%h/%b%b", cyc, out_valid, out_data, out_corrected, out_uncorrectable, hd, hc, hu);
            end
         end
         inflight  = sent - recv;
         exp_ready = !((inflight == 2) && !out_ready);
         checks++; if (in_ready !== exp_ready) begin errors++; $display("FAIL bp_in_ready cyc%0d: got %b expected %b", cyc, in_ready, exp_ready); end
         if (out_valid === 1'b1 && out_ready) begin
            checks++;
            if (out_data !== bp_data[recv] || {out_corrected, out_uncorrectable} !== bp_flag[recv]) begin
               errors++; $display("FAIL bp_word%0d: got %h/%b%b expected %h/%b", recv, out_data, out_corrected, out_uncorrectable, bp_data[recv], bp_flag[recv]);
            end
            recv++;
         end
         held = (out_valid === 1'b1) && !out_ready;
         hd = out_data; hc = out_corrected; hu = out_uncorrectable;
         if (in_valid && in_ready) sent++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      checks++; if (recv != 8 || sent != 8) begin errors++; $display("FAIL bp_count: got sent=%0d recv=%0d expected 8/8", sent, recv); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_extra_word: got out_valid=%b expected 0", out_valid); end
      checks++; if (corr_count !== 2'd3 || uncorr_count !== 2'd2 || uncorr_sticky !== 1'b1) begin errors++; $display("FAIL bp_stats: got %0d/%0d/%b expected 3/2/1", corr_count, uncorr_count, uncorr_sticky); end
   endtask

   task automatic test_reset_inflight();
      bit seen;
      out_ready = 1'b0; in_valid = 1'b1; in_cw = 12'h637;
      @(posedge clk); #1;
      in_cw = 12'h7C9;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL rst_prefill: got valid=%b ready=%b expected 1/0", out_valid, in_ready); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_flush: got valid=%b ready=%b expected 0/1", out_valid, in_ready); end
      checks++; if (corr_count !== 2'd0 || uncorr_count !== 2'd0 || uncorr_sticky !== 1'b0) begin errors++; $display("FAIL rst_stats: got %0d/%0d/%b expected 0/0/0", corr_count, uncorr_count, uncorr_sticky); end
      out_ready = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) seen = 1'b1;
      end
      checks++; if (seen) begin errors++; $display("FAIL rst_no_emit: got a word after reset expected none"); end
   endtask

   initial begin
      test_reset();
      test_clean();
      test_data_error();
      test_check_error();
      test_uncorrectable();
      test_saturation();
      test_clear_priority();
      test_backpressure();
      test_reset_inflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
